disp_scan_ctrl: RTL and testbench

- Time-multiplexes one shared 7-segment decoder across a 4-digit common-segment display.
- Each frame, latches four BCD digits and selects one digit at a time. Drives the digit code to the decoder and the matching one-hot digit-select onto SA.
- Inserts a dead-time blank before each digit to prevent ghosting, and supports leading-zero suppression and per-digit decimal point.
- Sits between the clock/counter datapath and the segment decoder.

---
 rtl/disp_scan_ctrl_if.sv | 22 ++
 rtl/disp_scan_ctrl.sv | 118 +++++++++++
 tb/tb_disp_scan_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/disp_scan_ctrl_if.sv
// Bundle of the scan controller's data-side inputs and decoder-side outputs.
// The master drives the digits and options; the slave is the scan controller.
interface disp_scan_ctrl_if;
  logic        ENABLE;
  logic [15:0] DATA;
  logic [3:0]  DP_MASK;
  logic        LZ_EN;
  logic [3:0]  COUNT;
  logic [3:0]  SA;
  logic        DP;
  logic        FRAME;

  modport master (
    output ENABLE, DATA, DP_MASK, LZ_EN,
    input  COUNT, SA, DP, FRAME
  );

  modport slave (
    input  ENABLE, DATA, DP_MASK, LZ_EN,
    output COUNT, SA, DP, FRAME
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with per-slot dead time,
// frame-synchronous data latch, leading-zero suppression and decimal points.
module disp_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000, // BLANK_CYC+1 .. 2^20-1
  parameter int unsigned BLANK_CYC = 2500   // >= 1
) (
  input  logic CLK,
  input  logic RST_N,
  disp_scan_ctrl_if.slave bus
);

  localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);
  localparam logic [19:0] BLANK_V  = 20'(BLANK_CYC);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // divcnt_q/idx_q/state_q describe the slot position presented at the next
  // edge; the output flops then hold that position for one cycle.
  scan_state_e state_q, state_d;
  logic [19:0] divcnt_q, divcnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  sa_q, sa_d;
  logic        dp_q, dp_d;
  logic        frame_q, frame_d;

  logic [3:0]  supp;
  logic        zero_run;
  logic        wrap;
  logic        frame_start;
  logic        lit;

  // Digit i blanks when it and every more significant latched digit are zero.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      zero_run = zero_run & (data_q[4*i +: 4] == 4'h0);
      supp[i]  = bus.LZ_EN & zero_run;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = ST_BLANK;
    divcnt_d    = '0;
    idx_d       = '0;
    data_d      = data_q;
    count_d     = 4'hF;
    sa_d        = 4'b0000;
    dp_d        = 1'b0;
    frame_d     = 1'b0;

    wrap        = (divcnt_q == DIV_LAST);
    frame_start = (divcnt_q == 20'd0) && (idx_q == 2'd0);
    lit         = (state_q == ST_SHOW) && !supp[idx_q];

    if (bus.ENABLE) begin
      frame_d = frame_start;
      if (frame_start) begin
        data_d = bus.DATA;
      end

      if (lit) begin
        sa_d    = 4'b0001 << idx_q;
        count_d = data_q[{idx_q, 2'b00} +: 4];
        dp_d    = bus.DP_MASK[idx_q];
      end

      if (wrap) begin
        divcnt_d = '0;
        idx_d    = idx_q + 2'd1;
      end else begin
        divcnt_d = divcnt_q + 20'd1;
        idx_d    = idx_q;
      end

      case (state_q)
        ST_BLANK: state_d = (divcnt_d == BLANK_V) ? ST_SHOW : ST_BLANK;
        ST_SHOW:  state_d = wrap ? ST_BLANK : ST_SHOW;
        default:  state_d = ST_BLANK;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_BLANK;
      divcnt_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      count_q  <= 4'hF;
      sa_q     <= 4'b0000;
      dp_q     <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      divcnt_q <= divcnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      count_q  <= count_d;
      sa_q     <= sa_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.COUNT = count_q;
  assign bus.SA    = sa_q;
  assign bus.DP    = dp_q;
  assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized self-checking bench for disp_scan_ctrl against a frame-position
// reference model (cycle number within the frame -> expected outputs).
module tb_disp_scan_ctrl;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME_LEN = 4 * SCAN_DIV;

  logic clk;
  logic rst_n;

  disp_scan_ctrl_if bus ();

  disp_scan_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: next frame position to present and the latched frame.
  int          k;
  logic [15:0] m_lat;
  logic [3:0]  e_sa;
  logic [3:0]  e_count;
  logic        e_dp;
  logic        e_frame;

  // Dead-time / one-hot tracking on observed SA.
  logic [3:0]  prev_sa;
  int          gap;
  bit          have_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    m_lat   = 16'h0000;
    e_sa    = 4'b0000;
    e_count = 4'hF;
    e_dp    = 1'b0;
    e_frame = 1'b0;
    prev_sa   = 4'b0000;
    gap       = 0;
    have_prev = 1'b0;
  endtask

  // Outputs the DUT should register at this edge, from the inputs seen at it.
  task automatic model_edge();
    int          pos;
    int          slot;
    int          off;
    logic [15:0] upper;
    bit          shown;
    if (!bus.ENABLE) begin
      e_sa    = 4'b0000;
      e_count = 4'hF;
      e_dp    = 1'b0;
      e_frame = 1'b0;
      k       = 0;
    end else begin
      pos  = k;
      slot = pos / SCAN_DIV;
      off  = pos % SCAN_DIV;
      if (pos == 0) m_lat = bus.DATA;
      upper   = m_lat >> (4 * slot);
      shown   = (off >= BLANK_CYC) && !(bus.LZ_EN && slot != 0 && upper == 16'h0);
      e_frame = (pos == 0);
      e_sa    = shown ? 4'(1 << slot) : 4'b0000;
      e_count = shown ? upper[3:0] : 4'hF;
      e_dp    = shown && bus.DP_MASK[slot];
      k       = (k + 1) % FRAME_LEN;
    end
  endtask

  task automatic compare_outputs();
    check("sa",    32'(bus.SA),    32'(e_sa));
    check("count", 32'(bus.COUNT), 32'(e_count));
    check("dp",    32'(bus.DP),    32'(e_dp));
    check("frame", 32'(bus.FRAME), 32'(e_frame));
    check("sa_onehot0", 32'($onehot0(bus.SA)), 32'd1);
    if (bus.SA != 4'b0000) begin
      if (prev_sa != 4'b0000) check("sa_stable", 32'(bus.SA), 32'(prev_sa));
      else if (have_prev)     check("dead_time_ok", 32'(gap >= BLANK_CYC), 32'd1);
      have_prev = 1'b1;
      gap       = 0;
    end else begin
      gap++;
    end
    prev_sa = bus.SA;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_outputs();
    end
  endtask

  function automatic int cur_pos();
    return (k + FRAME_LEN - 1) % FRAME_LEN;
  endfunction

  // Advance until the position just presented equals target (bounded).
  task automatic wait_pos(input int target);
    for (int i = 0; i < 2 * FRAME_LEN && cur_pos() != target; i++) run(1);
    check("wait_reach", 32'(cur_pos()), 32'(target));
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("arst_sa",    32'(bus.SA),    32'd0);
    check("arst_count", 32'(bus.COUNT), 32'hF);
    check("arst_dp",    32'(bus.DP),    32'd0);
    check("arst_frame", 32'(bus.FRAME), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_sa", 32'(bus.SA), 32'd0);
    model_reset();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] d;
    for (int i = 0; i < 4; i++)
      d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return d;
  endfunction

  initial begin
    rst_n       = 1'b0;
    bus.ENABLE  = 1'b1;
    bus.DATA    = 16'h1234;
    bus.DP_MASK = 4'b0000;
    bus.LZ_EN   = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sa",    32'(bus.SA),    32'd0);
    check("rst_count", 32'(bus.COUNT), 32'hF);
    check("rst_dp",    32'(bus.DP),    32'd0);
    check("rst_frame", 32'(bus.FRAME), 32'd0);
    rst_n = 1'b1;

    // Basic scan of 1234, two frames plus the next FRAME pulse.
    run(2 * FRAME_LEN + 1);

    // Leading-zero suppression on 0050, then the same data unsuppressed.
    bus.DATA  = 16'h0050;
    bus.LZ_EN = 1'b1;
    wait_pos(0);
    run(FRAME_LEN);
    bus.LZ_EN = 1'b0;
    run(FRAME_LEN);

    // All zeros with DP on digits 0 and 3: only digit 0 lit, DP on 3 dropped.
    bus.DATA    = 16'h0000;
    bus.LZ_EN   = 1'b1;
    bus.DP_MASK = 4'b1001;
    wait_pos(0);
    run(FRAME_LEN);
    bus.LZ_EN   = 1'b0;
    bus.DP_MASK = 4'b0000;

    // DATA change mid-frame must wait for the next frame.
    bus.DATA = 16'h1111;
    wait_pos(0);
    wait_pos(2 * SCAN_DIV + 3);
    bus.DATA = 16'h2222;
    wait_pos(0);
    run(FRAME_LEN);

    // ENABLE dropped during the SHOW of slot 1, then restored.
    wait_pos(SCAN_DIV + 4);
    bus.ENABLE = 1'b0;
    run(3);
    bus.ENABLE = 1'b1;
    run(FRAME_LEN + 4);

    // Asynchronous reset in the middle of a SHOW, then a fresh scan of 1234.
    bus.DATA = 16'h1234;
    wait_pos(SCAN_DIV + 5);
    async_reset();
    run(FRAME_LEN + 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.DATA    = rand_data();
      if ($urandom_range(0, 31) == 0) bus.DP_MASK = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) bus.LZ_EN   = ~bus.LZ_EN;
      bus.ENABLE = ($urandom_range(0, 99) != 0);
      run(1);
    end
    bus.ENABLE = 1'b1;
    wait_pos(SCAN_DIV + 3);
    async_reset();
    run(FRAME_LEN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
